adc_readout: RTL

- Downstream neighbour of the ADC conversion trigger.
- On each one-cycle `trigger` pulse (ADC conversion done), it reads one sample from the ADC over a read-only SPI link (it generates `sck` and samples `sdo`).
- Each sample is sign-extended and emitted as one AXI4-Stream beat toward the DMA.
- It asserts `tlast` every PACKET_LEN beats and returns a one-cycle `last` pulse to the trigger block so that block can stop after one complete transfer.

---
 rtl/adc_readout.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/adc_readout.sv
// ADC readout: one SPI sample per trigger, emitted sign-extended as an AXI4-Stream beat,
// with tlast every PACKET_LEN beats and a one-cycle last pulse back to the trigger block.
module adc_readout #(
  parameter int DATA_WIDTH = 18,
  parameter int SCK_DIV    = 2,
  parameter int PACKET_LEN = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        trigger,
  output logic        sck,
  input  logic        sdo,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        last,
  output logic        overflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(DATA_WIDTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PACKET_LEN - 1);

  logic [0:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  sck_q, sck_d;
  logic                  valid_q, valid_d;
  logic [31:0]           data_q, data_d;
  logic                  tlast_q, tlast_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  last_q, last_d;
  logic                  ovf_q, ovf_d;

  logic        tick, rise, done, hs, load, drop;
  logic [31:0] sample_ext;

  assign tick = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign rise = tick && !sck_q;
  // The completion cycle is the one whose edge ends the high phase of the last sck pulse.
  assign done = tick && sck_q && (bit_q == BIT_FULL);
  assign hs   = valid_q && m_axis_tready;
  assign load = done && (!valid_q || m_axis_tready);
  assign drop = done && valid_q && !m_axis_tready;

  assign sample_ext = 32'($signed(shift_q));

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no latch can be inferred.
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sck_d   = sck_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          div_d = '0;
          sck_d = !sck_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sdo};
          bit_d   = bit_q + BIT_W'(1);
        end
        if (done) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (hs) beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);

    valid_d = valid_q;
    data_d  = data_q;
    tlast_d = tlast_q;
    // A beat loading in the handshake cycle takes the post-handshake beat index.
    if (load) begin
      valid_d = 1'b1;
      data_d  = sample_ext;
      tlast_d = (beat_d == BEAT_LAST);
    end else if (hs) begin
      valid_d = 1'b0;
    end

    last_d = hs && tlast_q;
    ovf_d  = ovf_q || drop || ((state_q == SHIFT) && trigger);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      valid_q <= 1'b0;
      // NOTE: the data path is reset as well so tdata reads 0 straight out of reset.
      data_q  <= '0;
      tlast_q <= 1'b0;
      beat_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tlast_q <= tlast_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sck           = sck_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = tlast_q;
  assign last          = last_q;
  assign overflow      = ovf_q;

endmodule
